// File: rtl/gain_meter_pkg.sv
// gain_meter_pkg
// Shared definitions for the gain meter: the control FSM state encoding and
// the width helpers that derive the peak-to-peak, gain and window-counter
// widths from the top-level parameters.
package gain_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Difference of two signed DATA_W values needs one extra bit.
    function automatic int pp_width(input int data_w);
        return data_w + 1;
    endfunction

    // Gain is out_pp scaled by 2^q_frac, so it carries PP_W integer bits.
    function automatic int gain_width(input int data_w, input int q_frac);
        return pp_width(data_w) + q_frac;
    endfunction

    // Counter holding 0 .. win_len-1; never narrower than one bit.
    function automatic int cnt_width(input int win_len);
        return (win_len <= 2) ? 1 : $clog2(win_len);
    endfunction

endpackage

// File: rtl/gain_meter_div.sv
// gain_meter_div
// Unsigned restoring divider, one quotient bit per clock.
//   clk, rst  : clock and synchronous active-high reset
//   start     : one-cycle pulse; dividend/divisor are sampled on this edge
//   dividend  : DIVIDEND_W-bit unsigned numerator
//   divisor   : DIVISOR_W-bit unsigned, non-zero denominator
//   done      : one-cycle pulse, quotient valid from this cycle on
//   quotient  : floor(dividend / divisor), held until the next start
// The first quotient bit is resolved on the start edge itself, so the full
// quotient is ready after exactly DIVIDEND_W edges (start edge included).
module gain_meter_div #(
    parameter int DIVIDEND_W = 21,
    parameter int DIVISOR_W  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    // quot_q shifts dividend bits out of the top while quotient bits enter
    // at the bottom.
    logic [DIVIDEND_W-1:0] quot_q, quot_d, src_quot;
    logic [DIVISOR_W-1:0]  den_q, den_d, src_den;
    logic [DIVISOR_W-1:0]  rem_q, rem_d, src_rem;
    logic [DIVISOR_W:0]    trial, diff;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_next;
    logic                  active_q, active_d;
    logic                  done_q, done_d;

    always_comb begin
        src_quot = start ? dividend : quot_q;
        src_den  = start ? divisor  : den_q;
        src_rem  = start ? '0       : rem_q;
        // Remainder is always below the divisor, so the shifted trial value
        // fits in DIVISOR_W+1 bits and the difference sign bit is the
        // "divisor did not fit" flag.
        trial    = {src_rem, src_quot[DIVIDEND_W-1]};
        diff     = trial - {1'b0, src_den};
        cnt_next = start ? CNT_W'(1) : cnt_q + CNT_W'(1);

        quot_d   = quot_q;
        den_d    = den_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        done_d   = 1'b0;

        if (start || active_q) begin
            den_d = src_den;
            cnt_d = cnt_next;
            if (!diff[DIVISOR_W]) begin
                rem_d  = diff[DIVISOR_W-1:0];
                quot_d = {src_quot[DIVIDEND_W-2:0], 1'b1};
            end else begin
                rem_d  = trial[DIVISOR_W-1:0];
                quot_d = {src_quot[DIVIDEND_W-2:0], 1'b0};
            end
            if (cnt_next == CNT_W'(DIVIDEND_W)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end else begin
                active_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quot_q   <= '0;
            den_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            quot_q   <= quot_d;
            den_q    <= den_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quot_q;

endmodule

// File: rtl/gain_meter.sv
// gain_meter
// Measures peak-to-peak amplitude of paired stimulus/response samples over a
// window of WIN_LEN transfers and reports gain = out_pp / in_pp as an
// unsigned fixed-point value with Q_FRAC fractional bits.
//   clk, rst              : clock and synchronous active-high reset
//   start                 : begins a window (only honoured in IDLE)
//   busy                  : high whenever the FSM is not IDLE
//   s_valid/s_ready       : sample-pair handshake; s_ready high only in ACCUM
//   s_in, s_out           : signed stimulus / response samples
//   m_valid/m_ready       : result handshake; m_valid high only in HOLD
//   m_gain                : floor((out_pp << Q_FRAC) / in_pp), all ones on div0
//   m_in_pp, m_out_pp     : peak-to-peak of the last completed window
//   m_div0                : stimulus peak-to-peak was zero
// Result outputs are registers that only change when a DIVIDE completes (or
// on reset), so they stay stable through any HOLD stall and after it.
module gain_meter
    import gain_meter_pkg::*;
#(
    parameter int  DATA_W  = 12,
    parameter int  WIN_LEN = 1024,
    parameter int  Q_FRAC  = 8,
    localparam int PP_W    = pp_width(DATA_W),
    localparam int GAIN_W  = gain_width(DATA_W, Q_FRAC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_in,
    input  logic [DATA_W-1:0] s_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [GAIN_W-1:0] m_gain,
    output logic [PP_W-1:0]   m_in_pp,
    output logic [PP_W-1:0]   m_out_pp,
    output logic              m_div0
);

    localparam int CNT_W = cnt_width(WIN_LEN);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [DATA_W-1:0]  in_min_q, in_min_d, in_max_q, in_max_d;
    logic signed [DATA_W-1:0]  out_min_q, out_min_d, out_max_q, out_max_d;
    logic [PP_W-1:0]           in_pp_q, in_pp_d, out_pp_q, out_pp_d;
    logic                      div_phase_q, div_phase_d;
    logic                      div0_q, div0_d;
    logic [GAIN_W-1:0]         m_gain_q, m_gain_d;
    logic [PP_W-1:0]           m_in_pp_q, m_in_pp_d, m_out_pp_q, m_out_pp_d;
    logic                      m_div0_q, m_div0_d;

    logic [PP_W-1:0]           in_pp_c, out_pp_c;
    logic                      div_start, div_done;
    logic [GAIN_W-1:0]         div_quot;

    // Sign-extended subtraction; max >= min so the PP_W-bit result is exact.
    assign in_pp_c  = {in_max_q[DATA_W-1], in_max_q} - {in_min_q[DATA_W-1], in_min_q};
    assign out_pp_c = {out_max_q[DATA_W-1], out_max_q} - {out_min_q[DATA_W-1], out_min_q};

    gain_meter_div #(
        .DIVIDEND_W (GAIN_W),
        .DIVISOR_W  (PP_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({out_pp_c, {Q_FRAC{1'b0}}}),
        .divisor  (in_pp_c),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_min_d    = in_min_q;
        in_max_d    = in_max_q;
        out_min_d   = out_min_q;
        out_max_d   = out_max_q;
        in_pp_d     = in_pp_q;
        out_pp_d    = out_pp_q;
        div_phase_d = div_phase_q;
        div0_d      = div0_q;
        m_gain_d    = m_gain_q;
        m_in_pp_d   = m_in_pp_q;
        m_out_pp_d  = m_out_pp_q;
        m_div0_d    = m_div0_q;
        div_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCUM;
                    cnt_d   = '0;
                end
            end

            ST_ACCUM: begin
                // s_ready is implied by the state, so s_valid alone transfers.
                if (s_valid) begin
                    if (cnt_q == '0) begin
                        in_min_d  = $signed(s_in);
                        in_max_d  = $signed(s_in);
                        out_min_d = $signed(s_out);
                        out_max_d = $signed(s_out);
                    end else begin
                        if ($signed(s_in) < in_min_q)   in_min_d  = $signed(s_in);
                        if ($signed(s_in) > in_max_q)   in_max_d  = $signed(s_in);
                        if ($signed(s_out) < out_min_q) out_min_d = $signed(s_out);
                        if ($signed(s_out) > out_max_q) out_max_d = $signed(s_out);
                    end
                    if (cnt_q == CNT_W'(WIN_LEN - 1)) begin
                        state_d     = ST_DIVIDE;
                        div_phase_d = 1'b0;
                        div0_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_DIVIDE: begin
                // Phase 0: min/max now include the last sample; latch the
                // peak-to-peak values and either launch the divider or flag
                // div0. Phase 1: wait for the divider (or finish div0).
                if (!div_phase_q) begin
                    in_pp_d     = in_pp_c;
                    out_pp_d    = out_pp_c;
                    div_phase_d = 1'b1;
                    if (in_pp_c == '0) begin
                        div0_d = 1'b1;
                    end else begin
                        div_start = 1'b1;
                    end
                end else if (div0_q) begin
                    state_d    = ST_HOLD;
                    m_gain_d   = '1;
                    m_div0_d   = 1'b1;
                    m_in_pp_d  = in_pp_q;
                    m_out_pp_d = out_pp_q;
                end else if (div_done) begin
                    state_d    = ST_HOLD;
                    m_gain_d   = div_quot;
                    m_div0_d   = 1'b0;
                    m_in_pp_d  = in_pp_q;
                    m_out_pp_d = out_pp_q;
                end
            end

            ST_HOLD: begin
                if (m_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_min_q    <= '0;
            in_max_q    <= '0;
            out_min_q   <= '0;
            out_max_q   <= '0;
            in_pp_q     <= '0;
            out_pp_q    <= '0;
            div_phase_q <= 1'b0;
            div0_q      <= 1'b0;
            m_gain_q    <= '0;
            m_in_pp_q   <= '0;
            m_out_pp_q  <= '0;
            m_div0_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_min_q    <= in_min_d;
            in_max_q    <= in_max_d;
            out_min_q   <= out_min_d;
            out_max_q   <= out_max_d;
            in_pp_q     <= in_pp_d;
            out_pp_q    <= out_pp_d;
            div_phase_q <= div_phase_d;
            div0_q      <= div0_d;
            m_gain_q    <= m_gain_d;
            m_in_pp_q   <= m_in_pp_d;
            m_out_pp_q  <= m_out_pp_d;
            m_div0_q    <= m_div0_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign s_ready  = (state_q == ST_ACCUM);
    assign m_valid  = (state_q == ST_HOLD);
    assign m_gain   = m_gain_q;
    assign m_in_pp  = m_in_pp_q;
    assign m_out_pp = m_out_pp_q;
    assign m_div0   = m_div0_q;

endmodule

// File: tb/tb_gain_meter.sv
// tb_gain_meter
// Directed bench for gain_meter with DATA_W=12, WIN_LEN=8, Q_FRAC=8.
// Each window record holds two alternating sample pairs and the hand-computed
// peak-to-peak values, gain and div0 flag; multi-cycle corner cases (resets
// mid-window and mid-divide) are written out by hand.
module tb_gain_meter;

    localparam int DATA_W  = 12;
    localparam int WIN_LEN = 8;
    localparam int Q_FRAC  = 8;
    localparam int PP_W    = 13;
    localparam int GAIN_W  = 21;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic                     s_valid = 1'b0;
    logic                     m_ready = 1'b0;
    logic signed [DATA_W-1:0] s_in = '0;
    logic signed [DATA_W-1:0] s_out = '0;
    logic                     busy, s_ready, m_valid, m_div0;
    logic [GAIN_W-1:0]        m_gain;
    logic [PP_W-1:0]          m_in_pp, m_out_pp;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    always #5 clk = ~clk;

    gain_meter #(
        .DATA_W  (DATA_W),
        .WIN_LEN (WIN_LEN),
        .Q_FRAC  (Q_FRAC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_in     (s_in),
        .s_out    (s_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_gain   (m_gain),
        .m_in_pp  (m_in_pp),
        .m_out_pp (m_out_pp),
        .m_div0   (m_div0)
    );

    typedef struct {
        logic signed [DATA_W-1:0] in_a;
        logic signed [DATA_W-1:0] in_b;
        logic signed [DATA_W-1:0] out_a;
        logic signed [DATA_W-1:0] out_b;
        logic [PP_W-1:0]          in_pp;
        logic [PP_W-1:0]          out_pp;
        logic [GAIN_W-1:0]        gain;
        logic                     div0;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_s_ready"},  s_ready,  0);
        check({tag, "_m_valid"},  m_valid,  0);
        check({tag, "_m_gain"},   m_gain,   0);
        check({tag, "_m_in_pp"},  m_in_pp,  0);
        check({tag, "_m_out_pp"}, m_out_pp, 0);
        check({tag, "_m_div0"},   m_div0,   0);
    endtask

    // Full window: start, WIN_LEN transfers (optionally with gaps), measure
    // latency to m_valid, check the result, optional HOLD stall, handshake.
    task automatic run_window(input vec_t v, input bit gaps, input bit start_in_accum,
                              input int stall, input bit start_in_hold,
                              input bit start_with_ready);
        int sent = 0;
        int cyc  = 0;
        int lat  = 0;
        bit bad_ready = 1'b0;
        bit stable = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (sent < WIN_LEN && cyc < 200) begin
            cyc++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                // Extreme junk that would corrupt min/max if sampled.
                s_valid = 1'b0;
                s_in    = 12'sh7FF;
                s_out   = 12'sh800;
            end else begin
                s_valid = 1'b1;
                s_in    = (sent % 2 == 1) ? v.in_b  : v.in_a;
                s_out   = (sent % 2 == 1) ? v.out_b : v.out_a;
            end
            start = start_in_accum && (sent == 3);
            if (!s_ready) bad_ready = 1'b1;
            if (s_valid && s_ready) sent++;
            tick();
        end
        s_valid = 1'b0;
        start   = 1'b0;
        check("s_ready_during_accum", bad_ready, 0);
        check("window_transfers", sent, WIN_LEN);
        check("s_ready_drop", s_ready, 0);
        while (!m_valid && lat < 100) begin
            if (s_ready || !busy) bad_ready = 1'b1;
            tick();
            lat++;
        end
        check("divide_ready_busy", bad_ready, 0);
        check("latency", lat, v.div0 ? 2 : GAIN_W + 1);
        check("m_gain",   m_gain,   v.gain);
        check("m_in_pp",  m_in_pp,  v.in_pp);
        check("m_out_pp", m_out_pp, v.out_pp);
        check("m_div0",   m_div0,   v.div0);
        for (int i = 0; i < stall; i++) begin
            start = start_in_hold && (i == stall / 2);
            tick();
            start = 1'b0;
            if (!m_valid || s_ready || m_gain != v.gain || m_in_pp != v.in_pp ||
                m_out_pp != v.out_pp || m_div0 != v.div0) stable = 1'b0;
        end
        if (stall > 0) check("hold_stable", stable, 1);
        m_ready = 1'b1;
        start   = start_with_ready;
        tick();
        m_ready = 1'b0;
        start   = 1'b0;
        check("m_valid_drop", m_valid, 0);
        check("idle_after_ready", busy, 0);
        tick();
        check("start_ignored_idle", busy, 0);
        check("outputs_kept", m_gain, v.gain);
        $display("txn %0d: in_pp=%0d out_pp=%0d gain=%0d div0=%0b latency=%0d",
                 txn, m_in_pp, m_out_pp, m_gain, m_div0, lat);
        txn++;
    endtask

    initial begin
        bit leaked;
        vecs[0] = '{12'sd100,   -12'sd100,  12'sd250,   -12'sd250,  13'd200,  13'd500,  21'd640,      1'b0};
        vecs[1] = '{-12'sd2048, 12'sd2047,  -12'sd2048, 12'sd2047,  13'd4095, 13'd4095, 21'd256,      1'b0};
        vecs[2] = '{12'sd0,     12'sd1,     -12'sd2048, 12'sd2047,  13'd1,    13'd4095, 21'd1048320,  1'b0};
        vecs[3] = '{12'sd5,     12'sd5,     12'sd300,   -12'sd7,    13'd0,    13'd307,  21'h1FFFFF,   1'b1};
        vecs[4] = '{-12'sd300,  -12'sd100,  12'sd17,    12'sd20,    13'd200,  13'd3,    21'd3,        1'b0};
        vecs[5] = '{12'sd1000,  -12'sd1000, -12'sd50,   12'sd50,    13'd2000, 13'd100,  21'd12,       1'b0};
        vecs[6] = '{12'sd3,     12'sd10,    12'sd0,     12'sd1000,  13'd7,    13'd1000, 21'd36571,    1'b0};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_zero("reset");

        run_window(vecs[0], 0, 0, 0,  0, 0);
        run_window(vecs[1], 0, 0, 0,  0, 0);
        run_window(vecs[2], 0, 0, 0,  0, 0);
        run_window(vecs[3], 0, 0, 0,  0, 0);
        run_window(vecs[4], 1, 0, 10, 1, 0);
        run_window(vecs[5], 0, 1, 3,  0, 1);
        run_window(vecs[6], 1, 0, 0,  0, 0);

        // Reset after 4 transfers.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_in    = (i % 2 == 1) ? vecs[0].in_b  : vecs[0].in_a;
            s_out   = (i % 2 == 1) ? vecs[0].out_b : vecs[0].out_a;
            tick();
        end
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_accum");

        run_window(vecs[0], 0, 0, 0, 0, 0);

        // Reset in the fifth DIVIDE cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < WIN_LEN; i++) begin
            s_valid = 1'b1;
            s_in    = (i % 2 == 1) ? vecs[1].in_b  : vecs[1].in_a;
            s_out   = (i % 2 == 1) ? vecs[1].out_b : vecs[1].out_a;
            tick();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero("rst_divide");
        leaked = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_valid || busy) leaked = 1'b1;
            tick();
        end
        check("no_result_after_rst", leaked, 0);

        run_window(vecs[5], 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
